// File: rtl/pe_operand_feeder_pkg.sv
// Shared definitions for the PE operand feeder: FSM state encoding,
// buffer-select codes and the default data width.
package pe_operand_feeder_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  // Feeder control states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_GAP      = 2'd2,
    ST_WAIT_RES = 2'd3
  } feeder_state_e;

  // wr_sel codes.
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Index width needed to address a buffer of the given depth (at least 1 bit).
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pe_operand_feeder_if.sv
// Feeder-to-PE link: operand stream with start/valid/last framing out,
// dot-product result with its valid strobe back.
interface pe_operand_feeder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  pe_start;
  logic                  pe_valid_in;
  logic                  pe_last;
  logic [DATA_WIDTH-1:0] pe_a;
  logic [DATA_WIDTH-1:0] pe_b;
  logic [DATA_WIDTH-1:0] pe_c;
  logic                  pe_output_valid;

  // Feeder side.
  modport master (
    output pe_start, pe_valid_in, pe_last, pe_a, pe_b,
    input  pe_c, pe_output_valid
  );

  // PE side.
  modport slave (
    input  pe_start, pe_valid_in, pe_last, pe_a, pe_b,
    output pe_c, pe_output_valid
  );
endinterface

// File: rtl/pe_operand_feeder_ram.sv
// Operand buffer for the PE feeder: N x DATA_WIDTH, one synchronous write
// port, one asynchronous read port. Writes to addresses >= N are dropped.
module pe_operand_ram
  import pe_operand_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int N          = 16,
  parameter int ADDR_W     = $clog2(N) + 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int IW = idx_width(N);

  logic [DATA_WIDTH-1:0] mem_q [N];

  // Store one element per write strobe; out-of-range addresses are ignored.
  // NOTE: storage arrays carry no reset; a reset port would turn the array into flops with a huge reset fan-out.
  always_ff @(posedge clk) begin
    if (we && (waddr < ADDR_W'(N))) begin
      mem_q[waddr[IW-1:0]] <= wdata;
    end
  end

  assign rdata = (raddr < ADDR_W'(N)) ? mem_q[raddr[IW-1:0]] : '0;

endmodule

// File: rtl/pe_operand_feeder.sv
// PE operand feeder: holds one A-row and one B-column, streams the N pairs
// into the PE on go with start/valid_in/last framing, then captures the
// PE result. Build option FEEDER_GAP_EN inserts one idle cycle after every
// non-last pair (frame of 2N-1 cycles); otherwise pairs issue back-to-back.
module pe_operand_feeder
  import pe_operand_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int N          = 16,
  parameter int ADDR_W     = $clog2(N) + 1
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  wr_en,
  input  logic                  wr_sel,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  go,
  output logic                  busy,
  pe_operand_feeder_if.master   pe,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  result_valid
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

  feeder_state_e         state_q;
  logic [ADDR_W-1:0]     idx_q;
  logic [ADDR_W-1:0]     rd_idx;
  logic                  wr_fire;
  logic [DATA_WIDTH-1:0] a_rd, b_rd, a_word, b_word;

  logic                  busy_q, start_q, valid_q, last_q, result_valid_q;
  logic [DATA_WIDTH-1:0] a_q, b_q, result_q;

  // Buffers are only writable while idle.
  assign wr_fire = wr_en && (state_q == ST_IDLE);

  pe_operand_ram #(.DATA_WIDTH(DATA_WIDTH), .N(N), .ADDR_W(ADDR_W)) u_ram_a (
    .clk   (clk),
    .we    (wr_fire && (wr_sel == SEL_A)),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_idx),
    .rdata (a_rd)
  );

  pe_operand_ram #(.DATA_WIDTH(DATA_WIDTH), .N(N), .ADDR_W(ADDR_W)) u_ram_b (
    .clk   (clk),
    .we    (wr_fire && (wr_sel == SEL_B)),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_idx),
    .rdata (b_rd)
  );

  // Index of the pair that will be on the PE bus next cycle.
  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rd_idx = '0;
    if (state_q == ST_ISSUE) begin
      rd_idx = idx_q + 1'b1;
    end else if (state_q == ST_GAP) begin
      rd_idx = idx_q;
    end
  end

  // Forward a same-edge write to element 0 so go+wr_en streams the new value.
  always_comb begin
    a_word = a_rd;
    b_word = b_rd;
    if (wr_fire && (wr_addr == '0)) begin
      if (wr_sel == SEL_A) a_word = wr_data;
      else                 b_word = wr_data;
    end
  end

  // Control FSM with registered PE strobes, operands and result.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      busy_q         <= 1'b0;
      start_q        <= 1'b0;
      valid_q        <= 1'b0;
      last_q         <= 1'b0;
      a_q            <= '0;
      b_q            <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      start_q        <= 1'b0;
      valid_q        <= 1'b0;
      last_q         <= 1'b0;
      result_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (go) begin
            state_q <= ST_ISSUE;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            valid_q <= 1'b1;
            start_q <= 1'b1;
            last_q  <= (rd_idx == LAST_IDX);
            a_q     <= a_word;
            b_q     <= b_word;
          end
        end
        ST_ISSUE: begin
          if (idx_q == LAST_IDX) begin
            state_q <= ST_WAIT_RES;
          end else begin
            idx_q <= idx_q + 1'b1;
`ifdef FEEDER_GAP_EN
            state_q <= ST_GAP;
`else
            valid_q <= 1'b1;
            start_q <= (rd_idx == '0);
            last_q  <= (rd_idx == LAST_IDX);
            a_q     <= a_word;
            b_q     <= b_word;
`endif
          end
        end
        ST_GAP: begin
          state_q <= ST_ISSUE;
          valid_q <= 1'b1;
          start_q <= (rd_idx == '0);
          last_q  <= (rd_idx == LAST_IDX);
          a_q     <= a_word;
          b_q     <= b_word;
        end
        ST_WAIT_RES: begin
          if (pe.pe_output_valid) begin
            state_q        <= ST_IDLE;
            busy_q         <= 1'b0;
            result_q       <= pe.pe_c;
            result_valid_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy           = busy_q;
  assign pe.pe_start    = start_q;
  assign pe.pe_valid_in = valid_q;
  assign pe.pe_last     = last_q;
  assign pe.pe_a        = a_q;
  assign pe.pe_b        = b_q;
  assign result         = result_q;
  assign result_valid   = result_valid_q;

endmodule

// File: tb/tb_pe_operand_feeder.sv
// Self-checking bench for pe_operand_feeder: an N=16 instance for framing,
// result capture, busy filtering, bounds and reset abort, plus an N=1
// instance for the single-pair frame. The bench plays the PE.
module tb_pe_operand_feeder;
  import pe_operand_feeder_pkg::*;

  localparam int DW = 32;
  localparam int N  = 16;
  localparam int AW = $clog2(N) + 1;
`ifdef FEEDER_GAP_EN
  localparam int STRIDE = 2;
`else
  localparam int STRIDE = 1;
`endif
  localparam int FRAME = (N - 1) * STRIDE + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          clr_n;
  logic          wr_en, wr_sel, go, busy, result_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data, result;
  pe_operand_feeder_if #(.DATA_WIDTH(DW)) pe_if ();

  logic          wr_en_1, wr_sel_1, go_1, busy_1, result_valid_1;
  logic [0:0]    wr_addr_1;
  logic [DW-1:0] wr_data_1, result_1;
  pe_operand_feeder_if #(.DATA_WIDTH(DW)) pe_if1 ();

  pe_operand_feeder #(.DATA_WIDTH(DW), .N(N), .ADDR_W(AW)) dut (
    .clk(clk), .clr_n(clr_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .go(go), .busy(busy), .pe(pe_if.master),
    .result(result), .result_valid(result_valid)
  );

  pe_operand_feeder #(.DATA_WIDTH(DW), .N(1), .ADDR_W(1)) dut1 (
    .clk(clk), .clr_n(clr_n), .wr_en(wr_en_1), .wr_sel(wr_sel_1), .wr_addr(wr_addr_1),
    .wr_data(wr_data_1), .go(go_1), .busy(busy_1), .pe(pe_if1.master),
    .result(result_1), .result_valid(result_valid_1)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: buffer images and held bus values.
  logic [DW-1:0] a_mdl [N];
  logic [DW-1:0] b_mdl [N];
  logic [DW-1:0] exp_a_hold = '0;
  logic [DW-1:0] exp_b_hold = '0;
  logic [DW-1:0] exp_result = '0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic load_word(input logic sel, input int addr, input logic [DW-1:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = AW'(addr); wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
    if (addr < N) begin
      if (sel == SEL_A) a_mdl[addr] = data;
      else              b_mdl[addr] = data;
    end
  endtask

  // Pulse go and check every cycle of the frame plus the first wait cycle.
  task automatic run_frame(input string tag, input bit inject, input bit write0,
                           input logic [DW-1:0] w0);
    go = 1'b1;
    if (write0) begin
      wr_en = 1'b1; wr_sel = SEL_A; wr_addr = '0; wr_data = w0;
      a_mdl[0] = w0;
    end
    for (int c = 1; c <= FRAME + 1; c++) begin
      int off, k;
      bit ev;
      logic [2:0] exp_flags;
      @(negedge clk);
      go = 1'b0; wr_en = 1'b0;
      off = c - 1;
      k = off / STRIDE;
      ev = (off % STRIDE == 0) && (k < N);
      if (ev) begin exp_a_hold = a_mdl[k]; exp_b_hold = b_mdl[k]; end
      exp_flags = {ev, ev && (k == 0), ev && (k == N - 1)};
      n_cmp++;
      if ({pe_if.pe_valid_in, pe_if.pe_start, pe_if.pe_last} !== exp_flags) begin
        n_err++;
        $display("FAIL %s flags c=%0d: got %b want %b (valid,start,last)", tag, c,
                 {pe_if.pe_valid_in, pe_if.pe_start, pe_if.pe_last}, exp_flags);
      end
      n_cmp++;
      if (pe_if.pe_a !== exp_a_hold || pe_if.pe_b !== exp_b_hold) begin
        n_err++;
        $display("FAIL %s operands c=%0d: got %h/%h want %h/%h", tag, c,
                 pe_if.pe_a, pe_if.pe_b, exp_a_hold, exp_b_hold);
      end
      n_cmp++;
      if (busy !== 1'b1) begin
        n_err++;
        $display("FAIL %s busy c=%0d: got %b want 1", tag, c, busy);
      end
      if (inject && c == 5) begin
        go = 1'b1; wr_en = 1'b1; wr_sel = 1'($urandom_range(0, 1));
        wr_addr = AW'($urandom_range(0, N - 1)); wr_data = $urandom;
      end
    end
  endtask

  // Hold in WAIT_RES for delay cycles, then return pe_c and check capture.
  task automatic run_result(input string tag, input int delay, input logic [DW-1:0] cval,
                            input bit go_with_ov);
    for (int i = 1; i < delay; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({busy, pe_if.pe_valid_in, result_valid} !== 3'b100) begin
        n_err++;
        $display("FAIL %s wait: got busy,valid,rv=%b want 100", tag,
                 {busy, pe_if.pe_valid_in, result_valid});
      end
    end
    pe_if.pe_output_valid = 1'b1; pe_if.pe_c = cval; go = go_with_ov;
    @(negedge clk);
    pe_if.pe_output_valid = 1'b0; pe_if.pe_c = $urandom; go = 1'b0;
    exp_result = cval;
    n_cmp++;
    if (result_valid !== 1'b1 || result !== exp_result || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s capture: got rv=%b result=%h busy=%b want 1/%h/0", tag,
               result_valid, result, busy, exp_result);
    end
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if (result_valid !== 1'b0 || result !== exp_result || busy !== 1'b0 ||
          pe_if.pe_valid_in !== 1'b0) begin
        n_err++;
        $display("FAIL %s after: got rv=%b result=%h busy=%b valid=%b want 0/%h/0/0", tag,
                 result_valid, result, busy, pe_if.pe_valid_in, exp_result);
      end
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({busy, pe_if.pe_start, pe_if.pe_valid_in, pe_if.pe_last, result_valid} !== 5'b0 ||
        pe_if.pe_a !== '0 || pe_if.pe_b !== '0 || result !== '0) begin
      n_err++;
      $display("FAIL reset: outputs not zero (busy=%b a=%h b=%h result=%h)",
               busy, pe_if.pe_a, pe_if.pe_b, result);
    end
    n_cmp++;
    if ({busy_1, pe_if1.pe_valid_in, result_valid_1} !== 3'b0 || result_1 !== '0) begin
      n_err++;
      $display("FAIL reset_n1: outputs not zero (busy=%b result=%h)", busy_1, result_1);
    end
  endtask

  task automatic test_basic_frame();
    for (int k = 0; k < N; k++) begin
      load_word(SEL_A, k, 32'h3F80_0000);
      load_word(SEL_B, k, 32'h4000_0000);
    end
    run_frame("basic", 1'b0, 1'b0, '0);
    run_result("basic", 3, 32'h4200_0000, 1'b0);
  endtask

  task automatic test_busy_ignore();
    run_frame("busy_ignore", 1'b1, 1'b0, '0);
    run_result("busy_ignore", 2, $urandom, 1'b1);
    run_frame("rerun", 1'b0, 1'b0, '0);
    run_result("rerun", 1, $urandom, 1'b0);
  endtask

  task automatic test_random();
    repeat (3) begin
      for (int k = 0; k < N; k++) begin
        load_word(SEL_A, k, $urandom);
        load_word(SEL_B, k, $urandom);
      end
      run_frame("random", 1'b0, 1'b0, '0);
      run_result("random", int'($urandom_range(1, 6)), $urandom, 1'b0);
    end
  endtask

  task automatic test_go_with_write();
    run_frame("go_with_write", 1'b0, 1'b1, $urandom);
    run_result("go_with_write", 2, $urandom, 1'b0);
  endtask

  task automatic test_oob_and_stray();
    load_word(SEL_A, N, $urandom);
    load_word(SEL_B, int'($urandom_range(N, 2 * N - 1)), $urandom);
    pe_if.pe_output_valid = 1'b1; pe_if.pe_c = $urandom;
    @(negedge clk);
    pe_if.pe_output_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if (result_valid !== 1'b0 || result !== exp_result || busy !== 1'b0) begin
        n_err++;
        $display("FAIL stray_ov: got rv=%b result=%h busy=%b want 0/%h/0",
                 result_valid, result, busy, exp_result);
      end
    end
    run_frame("oob", 1'b0, 1'b0, '0);
    run_result("oob", 2, $urandom, 1'b0);
  endtask

  task automatic test_reset_mid();
    go = 1'b1;
    for (int c = 1; c <= 5 * STRIDE + 1; c++) begin
      @(negedge clk);
      go = 1'b0;
    end
    n_cmp++;
    if (pe_if.pe_valid_in !== 1'b1 || pe_if.pe_a !== a_mdl[5]) begin
      n_err++;
      $display("FAIL reset_mid pair5: got valid=%b a=%h want 1/%h",
               pe_if.pe_valid_in, pe_if.pe_a, a_mdl[5]);
    end
    clr_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, pe_if.pe_start, pe_if.pe_valid_in, pe_if.pe_last, result_valid} !== 5'b0 ||
        pe_if.pe_a !== '0 || pe_if.pe_b !== '0 || result !== '0) begin
      n_err++;
      $display("FAIL reset_mid async: got busy=%b valid=%b a=%h b=%h result=%h want all 0",
               busy, pe_if.pe_valid_in, pe_if.pe_a, pe_if.pe_b, result);
    end
    @(negedge clk);
    clr_n = 1'b1;
    exp_a_hold = '0; exp_b_hold = '0; exp_result = '0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || pe_if.pe_valid_in !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid release: got busy=%b valid=%b want 0/0", busy, pe_if.pe_valid_in);
    end
    run_frame("restart", 1'b0, 1'b0, '0);
    run_result("restart", 3, $urandom, 1'b0);
  endtask

  task automatic test_n1();
    logic [DW-1:0] a0, b0, cval;
    a0 = $urandom; b0 = $urandom; cval = $urandom;
    wr_en_1 = 1'b1; wr_sel_1 = SEL_A; wr_addr_1 = 1'b0; wr_data_1 = a0;
    @(negedge clk);
    wr_sel_1 = SEL_B; wr_data_1 = b0;
    @(negedge clk);
    wr_sel_1 = SEL_A; wr_addr_1 = 1'b1; wr_data_1 = ~a0;
    @(negedge clk);
    wr_en_1 = 1'b0; go_1 = 1'b1;
    @(negedge clk);
    go_1 = 1'b0;
    n_cmp++;
    if ({pe_if1.pe_valid_in, pe_if1.pe_start, pe_if1.pe_last} !== 3'b111 ||
        pe_if1.pe_a !== a0 || pe_if1.pe_b !== b0 || busy_1 !== 1'b1) begin
      n_err++;
      $display("FAIL n1 frame: got flags=%b a=%h b=%h busy=%b want 111/%h/%h/1",
               {pe_if1.pe_valid_in, pe_if1.pe_start, pe_if1.pe_last},
               pe_if1.pe_a, pe_if1.pe_b, busy_1, a0, b0);
    end
    @(negedge clk);
    n_cmp++;
    if ({pe_if1.pe_valid_in, pe_if1.pe_start, pe_if1.pe_last} !== 3'b000 ||
        pe_if1.pe_a !== a0 || busy_1 !== 1'b1) begin
      n_err++;
      $display("FAIL n1 wait: got flags=%b a=%h busy=%b want 000/%h/1",
               {pe_if1.pe_valid_in, pe_if1.pe_start, pe_if1.pe_last}, pe_if1.pe_a, busy_1, a0);
    end
    pe_if1.pe_output_valid = 1'b1; pe_if1.pe_c = cval;
    @(negedge clk);
    pe_if1.pe_output_valid = 1'b0;
    n_cmp++;
    if (result_valid_1 !== 1'b1 || result_1 !== cval || busy_1 !== 1'b0) begin
      n_err++;
      $display("FAIL n1 capture: got rv=%b result=%h busy=%b want 1/%h/0",
               result_valid_1, result_1, busy_1, cval);
    end
    @(negedge clk);
    n_cmp++;
    if (result_valid_1 !== 1'b0 || result_1 !== cval) begin
      n_err++;
      $display("FAIL n1 after: got rv=%b result=%h want 0/%h", result_valid_1, result_1, cval);
    end
  endtask

  initial begin
    clr_n = 1'b0;
    wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0; go = 1'b0;
    wr_en_1 = 1'b0; wr_sel_1 = 1'b0; wr_addr_1 = '0; wr_data_1 = '0; go_1 = 1'b0;
    pe_if.pe_c = '0;  pe_if.pe_output_valid = 1'b0;
    pe_if1.pe_c = '0; pe_if1.pe_output_valid = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    clr_n = 1'b1;
    @(negedge clk);
    test_basic_frame();
    test_busy_ignore();
    test_random();
    test_go_with_write();
    test_oob_and_stray();
    test_reset_mid();
    test_n1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
